// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-wide data BRAM
module load_store_unit #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0001_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [2:0]            i_req_funct3,
   input  logic [31:0]           i_req_addr,
   input  logic [31:0]           i_req_wdata,
   output logic                  o_resp_valid,
   output logic                  o_resp_err,
   output logic [31:0]           o_resp_rdata,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [31:0]           o_mem_wdata,
   output logic [3:0]            o_mem_wstrb,
   input  logic [31:0]           i_mem_rdata
);
   typedef enum logic [2:0] {S_IDLE, S_STORE, S_LOAD_ADDR, S_LOAD_DATA, S_ERR} state_t;
   state_t                r_state, w_next;
   logic [2:0]            r_funct3;
   logic [1:0]            r_off;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_wdata;
   logic                  w_accept, w_range_err, w_illegal, w_misalign, w_err;
   logic [31:0]           w_wdata_rep, w_load;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [3:0]            w_strb;

   assign o_req_ready = (r_state == S_IDLE);
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_range_err = i_req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2];
   assign w_illegal   = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11) || (i_req_we && i_req_funct3[2]);
   assign w_misalign  = (i_req_funct3[1:0] == 2'b01 && i_req_addr[0]) ||
                        (i_req_funct3[1:0] == 2'b10 && i_req_addr[1:0] != 2'b00);
   assign w_err       = w_range_err || w_illegal || w_misalign;
   assign w_wdata_rep = (i_req_funct3[1:0] == 2'b00) ? {4{i_req_wdata[7:0]}} :
                        (i_req_funct3[1:0] == 2'b01) ? {2{i_req_wdata[15:0]}} : i_req_wdata;
   assign w_strb      = (r_funct3[1:0] == 2'b00) ? (4'b0001 << r_off) :
                        (r_funct3[1:0] == 2'b01) ? (4'b0011 << r_off) : 4'b1111;
   assign w_byte      = i_mem_rdata[8*r_off +: 8];
   assign w_half      = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
   assign w_load      = (r_funct3[1:0] == 2'b00) ? {{24{~r_funct3[2] & w_byte[7]}}, w_byte} :
                        (r_funct3[1:0] == 2'b01) ? {{16{~r_funct3[2] & w_half[15]}}, w_half} : i_mem_rdata;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Latch request fields and the BRAM word address/lane-replicated data on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_funct3    <= '0;
         r_off       <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_accept) begin
         r_funct3    <= i_req_funct3;
         r_off       <= i_req_addr[1:0];
         r_mem_addr  <= i_req_addr[ADDR_WIDTH+1:2];
         r_mem_wdata <= w_wdata_rep;
      end
   end

   // Next state and state-decoded outputs; write enable and strobes depend only on state
   always_comb begin
      w_next       = r_state;
      o_mem_we     = 1'b0;
      o_mem_wstrb  = 4'b0000;
      o_resp_valid = 1'b0;
      o_resp_err   = 1'b0;
      o_resp_rdata = 32'h0;
      case (r_state)
         S_IDLE:      w_next = !w_accept ? S_IDLE : w_err ? S_ERR : i_req_we ? S_STORE : S_LOAD_ADDR;
         S_STORE: begin
            o_mem_we     = 1'b1;
            o_mem_wstrb  = w_strb;
            o_resp_valid = 1'b1;
            w_next       = S_IDLE;
         end
         S_LOAD_ADDR: w_next = S_LOAD_DATA;
         S_LOAD_DATA: begin
            o_resp_valid = 1'b1;
            o_resp_rdata = w_load;
            w_next       = S_IDLE;
         end
         S_ERR: begin
            o_resp_valid = 1'b1;
            o_resp_err   = 1'b1;
            w_next       = S_IDLE;
         end
         default:     w_next = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
   localparam logic [31:0] BASE = 32'h0001_0000;
   logic        clk, rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   logic [31:0] bram [0:4095];
   logic [31:0] bram_q;
   logic        fill_en;
   logic [11:0] fill_addr;
   logic [31:0] fill_data;
   logic [7:0]  ref_b [0:16383];

   int n_chk = 0, n_err = 0, cyc = 0, last_acc = 0, prev_lat = 0;
   logic [31:0] last_rd;

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_resp_valid(resp_valid), .o_resp_err(resp_err), .o_resp_rdata(resp_rdata),
      .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata)
   );

   assign mem_rdata = bram_q;

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (fill_en) bram[fill_addr] <= fill_data;
      else for (int b = 0; b < 4; b++) if (mem_we && mem_wstrb[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      bram_q <= bram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit commit, output logic err, output logic [31:0] rd, output int lat,
                        output logic [3:0] strb, output logic [31:0] mwd);
      int size, off, idx;
      logic [31:0] v;
      bit inr, bad_f3;
      size   = 1 << f3[1:0];
      off    = int'(a % 4);
      inr    = (a >= BASE) && (a < BASE + 32'd16384);
      idx    = int'(a - BASE);
      bad_f3 = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
      err    = !inr || bad_f3 || ((a % size) != 0);
      rd = 0; strb = 0; mwd = 0; lat = 1;
      if (!err && we) begin
         strb = 4'(((1 << size) - 1) << off);
         for (int j = 0; j < 4; j++) mwd[8*j +: 8] = wd[8*(j % size) +: 8];
         if (commit) for (int i = 0; i < size; i++) ref_b[idx+i] = wd[8*i +: 8];
      end else if (!err) begin
         lat = 2;
         v = 0;
         for (int i = 0; i < size; i++) v = v | (32'(ref_b[idx+i]) << (8*i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         rd = v;
      end
   endtask

   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int t = 0;
      while (!req_ready && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) chk("ready_timeout", 0, 1);
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = BASE + ($urandom & 32'h3FFC); req_wdata = $urandom;
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input bit chk_gap);
      logic e_err, we_seen, rdy_seen;
      logic [31:0] e_rd, e_wd;
      logic [3:0] e_strb;
      int e_lat, got;
      model(we, f3, a, wd, 1, e_err, e_rd, e_lat, e_strb, e_wd);
      drive(we, f3, a, wd);
      if (chk_gap) chk("accept_gap", 32'(cyc - last_acc), 32'(prev_lat + 1));
      last_acc = cyc; prev_lat = e_lat;
      got = 0; we_seen = 0; rdy_seen = 0;
      for (int k = 1; k <= 4; k++) if (got == 0) begin
         @(negedge clk);
         if (resp_valid) got = k;
         else begin
            we_seen  = we_seen | mem_we;
            rdy_seen = rdy_seen | req_ready;
         end
      end
      chk("latency", 32'(got), 32'(e_lat));
      chk("resp_err", 32'(resp_err), 32'(e_err));
      chk("resp_rdata", resp_rdata, e_rd);
      chk("mem_we", 32'(mem_we), 32'(we && !e_err));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
      chk("busy_ready", 32'(rdy_seen | req_ready), 0);
      chk("early_we", 32'(we_seen), 0);
      if (!e_err) chk("mem_addr", 32'(mem_addr), (a - BASE) >> 2);
      if (!e_err && we) chk("mem_wdata", mem_wdata, e_wd);
      last_rd = resp_rdata;
      req_valid = 0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 1);
      chk({tag, "_rvalid"}, 32'(resp_valid), 0);
      chk({tag, "_rerr"}, 32'(resp_err), 0);
      chk({tag, "_rdata"}, resp_rdata, 0);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_wstrb"}, 32'(mem_wstrb), 0);
      chk({tag, "_maddr"}, 32'(mem_addr), 0);
      chk({tag, "_mwdata"}, mem_wdata, 0);
   endtask

   initial begin
      logic [31:0] w, a;
      logic [2:0] f3;
      logic we;
      int r;
      rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
      fill_en = 1; fill_addr = 0; fill_data = 0;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         w = $urandom;
         fill_addr = 12'(i); fill_data = w;
         for (int j = 0; j < 4; j++) ref_b[4*i+j] = w[8*j +: 8];
      end
      @(negedge clk);
      fill_en = 0;
      chk_reset_outs("reset");
      rst_n = 1;
      @(negedge clk);

      do_req(1, 3'b010, 32'h0001_0010, 32'h1234_5678, 0);
      do_req(0, 3'b010, 32'h0001_0010, 0, 0);
      chk("lw_const", last_rd, 32'h1234_5678);
      do_req(1, 3'b000, 32'h0001_0013, 32'h0000_00A5, 0);
      do_req(0, 3'b000, 32'h0001_0013, 0, 0);
      chk("lb_const", last_rd, 32'hFFFF_FFA5);
      do_req(0, 3'b100, 32'h0001_0013, 0, 0);
      chk("lbu_const", last_rd, 32'h0000_00A5);
      do_req(0, 3'b010, 32'h0001_0010, 0, 0);
      chk("word4_const", last_rd, 32'hA534_5678);
      do_req(1, 3'b001, 32'h0001_0022, 32'h0000_8001, 0);
      do_req(0, 3'b001, 32'h0001_0022, 0, 0);
      chk("lh_const", last_rd, 32'hFFFF_8001);
      do_req(0, 3'b101, 32'h0001_0022, 0, 0);
      chk("lhu_const", last_rd, 32'h0000_8001);
      do_req(0, 3'b010, 32'h0001_0002, 0, 0);
      do_req(0, 3'b001, 32'h0001_0001, 0, 0);
      do_req(1, 3'b010, 32'h0002_0000, 32'hDEAD_BEEF, 0);
      do_req(0, 3'b011, 32'h0001_0000, 0, 0);
      do_req(1, 3'b100, 32'h0001_0000, 32'h1111_1111, 0);

      do_req(1, 3'b010, 32'h0001_0040, 32'hCAFE_F00D, 0);
      do_req(0, 3'b010, 32'h0001_0040, 0, 1);
      do_req(1, 3'b000, 32'h0001_0041, 32'h0000_0077, 1);
      do_req(0, 3'b010, 32'h0001_0040, 0, 1);

      drive(0, 3'b010, 32'h0001_0040, 0);
      #2 rst_n = 0;
      #1 chk_reset_outs("rst_load");
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_load_noresp", 32'(resp_valid), 0);
      end
      req_valid = 0; rst_n = 1;
      #1 chk("rst_load_ready", 32'(req_ready), 1);
      @(negedge clk);
      do_req(0, 3'b010, 32'h0001_0040, 0, 0);

      drive(1, 3'b010, 32'h0001_0080, 32'h5555_AAAA);
      chk("rst_store_we_pre", 32'(mem_we), 1);
      #1 rst_n = 0;
      #1 chk("rst_store_we", 32'(mem_we), 0);
      @(negedge clk);
      chk("rst_store_noresp", 32'(resp_valid), 0);
      req_valid = 0; rst_n = 1;
      @(negedge clk);
      do_req(0, 3'b010, 32'h0001_0080, 0, 0);

      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom);
         f3 = 3'($urandom);
         r = int'($urandom_range(0, 99));
         a = (r < 8) ? $urandom : BASE + $urandom_range(0, 16383);
         if (r >= 30) a = a & ~32'(((1 << f3[1:0]) - 1) & 3);
         do_req(we, f3, a, $urandom, n != 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
